// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide opcode and sequencer state encodings,
// the iteration count, and small helpers used by the HI/LO sequencer.
package cpu_pkg;

  localparam int MULDIV_ITER = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } muldiv_state_t;

  // True for the two's-complement variants (MULT, DIV).
  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  // True for the divide variants (DIV, DIVU).
  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Magnitude of a 32-bit operand when treated as signed; raw value otherwise.
  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Multicycle multiply/divide sequencer owning the HI/LO pair.
// IDLE latches operand magnitudes, RUN does one shift-add or restoring-divide
// step per cycle, SIGN applies sign correction and writes HI/LO.
module muldiv_ctrl
  import cpu_pkg::*;
#(
  parameter int ITER = MULDIV_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int CNT_W = $clog2(ITER);

  muldiv_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  muldiv_op_t       op_q;
  logic [31:0]      opa_q;      // |a|: multiplicand or dividend magnitude
  logic [31:0]      opb_q;      // |b|: divisor magnitude (multiplier lives in acc)
  logic             sign_a;     // a was negative and the op is signed
  logic             sign_b;     // b was negative and the op is signed
  logic             div_zero;   // divisor was zero at issue
  logic [63:0]      acc;

  logic             last_iter;
  logic             accept;
  logic [32:0]      mul_sum;
  logic [32:0]      div_trial;
  logic             div_ge;
  logic [31:0]      div_rem;
  logic [63:0]      acc_step;
  logic [63:0]      mul_res;
  logic [31:0]      quo_res;
  logic [31:0]      rem_res;
  logic [31:0]      dividend;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  assign last_iter = (cnt == CNT_W'(ITER - 1));
  assign accept    = (state == IDLE) && start;
  assign busy      = (state != IDLE);
  assign stall     = busy && (start || rd_hilo || wr_hi || wr_lo);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for ITER cycles, SIGN for one.
  always_comb begin
    // NOTE: combinational blocks assign a default first so no path leaves the
    // output unassigned; a missing default infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of the datapath, selected by the latched operation.
  always_comb begin
    // NOTE: always_comb uses blocking '=' so later lines see the values just
    // computed; clocked blocks use '<=' so all registers update together.
    // Multiply: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand when the multiplier LSB is set, then shift right.
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opa_q : 32'd0)};
    // Divide: acc = {remainder, dividend bits still to shift in / quotient}.
    div_trial = {acc[63:32], acc[31]};
    div_ge    = (div_trial >= {1'b0, opb_q});
    div_rem   = div_trial[31:0] - opb_q;
    if (is_div_op(op_q))
      acc_step = div_ge ? {div_rem, acc[30:0], 1'b1}
                        : {div_trial[31:0], acc[30:0], 1'b0};
    else
      acc_step = {mul_sum, acc[31:1]};
  end

  // Sign correction of the magnitude result, applied in SIGN.
  always_comb begin
    mul_res  = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
    quo_res  = (sign_a ^ sign_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_res  = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
    dividend = sign_a ? (~opa_q + 32'd1) : opa_q;
    if (!is_div_op(op_q)) begin
      res_hi = mul_res[63:32];
      res_lo = mul_res[31:0];
    end else if (div_zero) begin
      res_hi = dividend;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem_res;
      res_lo = quo_res;
    end
  end

  // Architectural HI/LO and the done pulse: operation results in SIGN,
  // MTHI/MTLO only while IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= (state == SIGN);
      if (state == SIGN) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end

  // Operand latch, iteration counter and accumulator.
  // NOTE: these datapath registers carry no reset: every operation reloads
  // them on accept, and nothing observes them outside RUN/SIGN.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op;
      opa_q    <= mag32(a, is_signed_op(op));
      opb_q    <= mag32(b, is_signed_op(op));
      sign_a   <= is_signed_op(op) && a[31];
      sign_b   <= is_signed_op(op) && b[31];
      div_zero <= (b == 32'd0);
      cnt      <= '0;
      if (is_div_op(op)) acc <= {32'd0, mag32(a, is_signed_op(op))};
      else               acc <= {32'd0, mag32(b, is_signed_op(op))};
    end else if (state == RUN) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO pushed to a scoreboard at
// issue and popped on each done pulse; latency, stall and reset checked inline.
module tb_muldiv_ctrl;
  import cpu_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a, b;
  logic        rd_hilo, wr_hi, wr_lo;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          edge_cnt = 0;
  int          t0 = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  muldiv_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_hilo (rd_hilo),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wdata   (wdata),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic issue(input muldiv_op_t o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; op = o; a = va; b = vb;
    sb.push_back('{hi: ehi, lo: elo});
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
    t0 = edge_cnt;
    check("accept_busy", busy, 1'b1);
  endtask

  // Waits (bounded) for done, then checks latency, flags and scoreboard head.
  task automatic wait_done(input string tag);
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_latency"}, 64'(edge_cnt - t0), 64'd33);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_stall_low"}, stall, 1'b0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_hi"}, hi, e.hi);
      check({tag, "_lo"}, lo, e.lo);
      cur_hi = e.hi;
      cur_lo = e.lo;
    end else begin
      check({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
    rd_hilo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);

    // Arithmetic corners, issued back-to-back in the done cycle.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done("multu_max");
    issue(MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done("mult_neg");
    issue(MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    wait_done("mult_min");
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div_neg");
    issue(DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    wait_done("divu_zero");
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    wait_done("div_ovf");
    issue(DIV, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFF6, 32'hFFFF_FFFF);
    wait_done("div_zero_neg");

    // Contention during RUN: MFHI/MFLO, MTLO and a second start at counter 5.
    issue(MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    repeat (5) @(negedge clk);
    rd_hilo = 1'b1;
    #1 check("run_rd_stall", stall, 1'b1);
    check("run_rd_hi", hi, cur_hi);
    check("run_rd_lo", lo, cur_lo);
    @(negedge clk);
    rd_hilo = 1'b0; wr_lo = 1'b1; wdata = 32'h0000_1234;
    #1 check("run_wr_stall", stall, 1'b1);
    @(negedge clk);
    wr_lo = 1'b0;
    check("run_wr_ignored", lo, cur_lo);
    start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd33;
    sb.push_back('{hi: 32'd10, lo: 32'd30});
    #1 check("run_start_stall", stall, 1'b1);
    check("run_hold_hi", hi, cur_hi);
    wait_done("held_first");
    @(negedge clk);
    start = 1'b0;
    t0 = edge_cnt;
    check("held_accept_busy", busy, 1'b1);
    wait_done("held_second");

    // MTHI in IDLE, then MTLO coinciding with a start.
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'hAAAA_0000;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_idle", hi, 32'hAAAA_0000);
    wr_lo = 1'b1; wdata = 32'h0000_BBBB;
    issue(MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
    wr_lo = 1'b0;
    check("mtlo_with_start", lo, 32'h0000_BBBB);
    check("mthi_kept", hi, 32'hAAAA_0000);
    wait_done("multu_small");

    // Reset mid-operation at counter 10, then a full-latency DIVU.
    @(negedge clk);
    issue(MULTU, 32'h1234_5678, 32'd9, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    void'(sb.pop_back());
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) break;
    end
    check("midrst_no_done", done, 1'b0);
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done("divu_after_rst");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
